fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer that consumes the program counter's address and drives the PC's jump/increment controls.
- Per instruction: fetches from program memory over a req/ack handshake, latches the instruction register (IR), decodes, then either redirects the PC or runs one data-memory access.
- Sits between pc (addr_o, jmp_en_i, jmp_addr_i), the unified memory and the accumulator datapath of the AC machine.

Parameters:
- ADDR_W, 5, address width; matches pc.
- DATA_W, 8, memory word / instruction width.
- OP_W, 3, opcode field width. Instruction layout: IR[7:5]=opcode, IR[4:0]=operand address.
- TIMEOUT, 15, max cycles waiting for mem_ack_i. Used only with the optional feature.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_addr_i  in  ADDR_W  current PC value (pc.addr_o).
- pc_inc_o  out  1  PC increment pulse.
- jmp_en_o  out  1  PC load pulse (to pc.jmp_en_i).
- jmp_addr_o  out  ADDR_W  jump target (to pc.jmp_addr_i).
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1=write, 0=read.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  write data (= acc_i).
- mem_ack_i  in  1  completes the request in the same cycle.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1.
- acc_i  in  DATA_W  accumulator value.
- acc_zero_i  in  1  accumulator == 0.
- acc_ld_o  out  1  accumulator load pulse.
- alu_op_o  out  2  00 pass, 01 add, 10 sub.
- ir_o  out  DATA_W  instruction register.
- halted_o  out  1  processor halted.
- err_o  out  1  timeout error; only with the optional feature, otherwise tied 0.

Behaviour:
- Opcodes: 000 NOP, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 HLT.
- States: S_FETCH, S_DECODE, S_MEM, S_HALT.
- Reset: state=S_FETCH, ir_o=0, halted_o=0, err_o=0. All pulse outputs are 0 and the memory interface is idle in the reset cycle.
- Reset mid-operation: request aborts at the next edge; a late ack is ignored.
- S_FETCH:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=pc_addr_i.
  - On mem_ack_i: ir<=mem_rdata_i, go to S_DECODE.
  - Otherwise stay; req is held high until ack.
- S_DECODE (exactly 1 cycle; outputs combinational from state + IR):
  - JMP: jmp_en_o=1, jmp_addr_o=IR[4:0] -> S_FETCH.
  - JZ: if acc_zero_i, behave as JMP; else pc_inc_o=1 -> S_FETCH.
  - NOP: pc_inc_o=1 -> S_FETCH.
  - LDA/ADD/SUB/STA: pc_inc_o=1 -> S_MEM.
  - HLT: no pulse -> S_HALT.
  - jmp_en_o and pc_inc_o are never both 1.
- S_MEM:
  - mem_req_o=1, mem_addr_o=IR[4:0], mem_we_o=(op==STA).
  - On ack:
    - LDA: acc_ld_o=1, alu_op_o=00.
    - ADD: acc_ld_o=1, alu_op_o=01.
    - SUB: acc_ld_o=1, alu_op_o=10.
    - STA: write completes; no acc_ld_o.
    - Next state S_FETCH.
- S_HALT: halted_o=1, no requests; exits only on rst_i.
- Address wrap: PC 31 + inc -> 0 is handled by pc; this block places no limit.
- Minimum cycles per instruction, with ack in the first request cycle:
  - Fetch-only (NOP/JMP/JZ): 2.
  - Memory instructions: 3.

Optional Feature:
- Macro: FETCH_CTRL_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to S_FETCH/S_MEM and increments each cycle without ack.
  - When the counter reaches TIMEOUT, the block enters S_HALT with err_o=1 and halted_o=1, both sticky until reset.
- Undefined:
  - No counter; the block waits indefinitely.
  - err_o is tied 0.

Decomposition:
- Package sim_ac_pkg holds opcode constants, state encoding, alu_op codes, ADDR_W/DATA_W defaults.
- One sub-module, instr_decoder: combinational IR -> {is_jmp, is_jz, is_mem, is_store, is_halt, alu_op}.

Test Plan:
- Reset, then memory returns 8'h00 (NOP) at addr 0 with immediate ack -> pc_inc_o pulses 1 cycle in S_DECODE; next fetch request uses the new PC.
- IR=8'hB9 (JMP 25) -> jmp_en_o=1, jmp_addr_o=25, pc_inc_o=0 for one cycle; next mem_addr_o=25.
- IR=8'hC3 (JZ 3) with acc_zero_i=1 -> jump to 3. Same instruction with acc_zero_i=0 -> pc_inc_o only.
- IR=8'h65 (ADD 5), ack delayed 3 cycles, rdata=8'h07 -> mem_req_o held high for 4 cycles at addr 5; acc_ld_o=1 with alu_op_o=01 in the ack cycle.
- IR=8'h4A (STA 10), acc_i=8'h2C -> mem_we_o=1, mem_addr_o=10, mem_wdata_o=8'h2C. Then IR=8'hE0 (HLT) -> halted_o=1, no further requests.
- rst_i asserted mid S_MEM with ack arriving the next cycle -> state S_FETCH, ack ignored, acc_ld_o stays 0. With FETCH_CTRL_TIMEOUT_EN and no ack for 15 cycles -> err_o=1, halted_o=1.

Source files
------------

// File: rtl/sim_ac_pkg.sv
// Shared definitions for the AC-machine fetch/decode sequencer.
// Holds the default widths, the opcode and state encodings, the ALU
// operation codes and the decoded-instruction bundle passed from
// instr_decoder to fetch_ctrl.
package sim_ac_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 8;
    localparam int OP_W_DEF    = 3;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_STA = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_MEM    = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef struct packed {
        logic       is_jmp;
        logic       is_jz;
        logic       is_mem;    // LDA/STA/ADD/SUB: needs a data-memory cycle
        logic       is_store;
        logic       is_halt;
        logic [1:0] alu_op;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder for the AC machine.
// Ports:
//   op   in   OP_W  opcode field of the instruction register
//   dec  out  dec_t decoded class flags and ALU operation
module instr_decoder
    import sim_ac_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic [OP_W-1:0] op,
    output dec_t            dec
);

    always_comb begin
        dec = '0;
        case (opcode_e'(op))
            OP_LDA: begin dec.is_mem = 1'b1; dec.alu_op = ALU_PASS; end
            OP_STA: begin dec.is_mem = 1'b1; dec.is_store = 1'b1; end
            OP_ADD: begin dec.is_mem = 1'b1; dec.alu_op = ALU_ADD; end
            OP_SUB: begin dec.is_mem = 1'b1; dec.alu_op = ALU_SUB; end
            OP_JMP: dec.is_jmp  = 1'b1;
            OP_JZ:  dec.is_jz   = 1'b1;
            OP_HLT: dec.is_halt = 1'b1;
            default: ;  // NOP
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction sequencer for the AC machine: fetches from memory at the PC,
// latches IR, decodes, then redirects the PC or runs one data access.
// Optional feature macro: FETCH_CTRL_TIMEOUT_EN adds a wait counter that
// halts with err_o when mem_ack_i does not arrive within TIMEOUT cycles.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   pc_addr_i               current PC
//   pc_inc_o, jmp_en_o      PC control pulses; jmp_addr_o is the target
//   mem_req_o/we_o/addr_o/wdata_o, mem_ack_i/rdata_i   memory handshake
//   acc_i, acc_zero_i       accumulator value / zero flag
//   acc_ld_o, alu_op_o      accumulator load pulse and ALU operation
//   ir_o, halted_o, err_o   instruction register, halt and timeout status
module fetch_ctrl
    import sim_ac_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic              pc_inc_o,
    output logic              jmp_en_o,
    output logic [ADDR_W-1:0] jmp_addr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic              acc_zero_i,
    output logic              acc_ld_o,
    output logic [1:0]        alu_op_o,
    output logic [DATA_W-1:0] ir_o,
    output logic              halted_o,
    output logic              err_o
);

    state_e            state, state_nxt;
    logic [DATA_W-1:0] ir;
    dec_t              dec;
    logic              timeout_hit;

    instr_decoder #(.OP_W(OP_W)) u_dec (
        .op  (ir[DATA_W-1 -: OP_W]),
        .dec (dec)
    );

`ifdef FETCH_CTRL_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err;
    logic       waiting;

    assign waiting     = (state == S_FETCH || state == S_MEM) && !mem_ack_i;
    assign timeout_hit = waiting && (wait_cnt == 4'(TIMEOUT - 1));

    // Counter is zero whenever we are outside a request state, so every
    // entry to S_FETCH/S_MEM starts from a clean count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 4'd1 : 4'd0;
            if (timeout_hit)
                err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    logic unused_timeout;
    assign unused_timeout = |4'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ack_i)
                ir <= mem_rdata_i;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_inc_o   = 1'b0;
        jmp_en_o   = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = pc_addr_i;
        acc_ld_o   = 1'b0;
        alu_op_o   = ALU_PASS;

        case (state)
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i)        state_nxt = S_DECODE;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_DECODE: begin
                if (dec.is_jmp || (dec.is_jz && acc_zero_i)) begin
                    jmp_en_o  = 1'b1;
                    state_nxt = S_FETCH;
                end else if (dec.is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    // PC advances here so the post-access fetch already
                    // sees the next address.
                    pc_inc_o  = 1'b1;
                    state_nxt = dec.is_mem ? S_MEM : S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                mem_we_o   = dec.is_store;
                mem_addr_o = ir[ADDR_W-1:0];
                if (mem_ack_i) begin
                    acc_ld_o  = !dec.is_store;
                    alu_op_o  = dec.alu_op;
                    state_nxt = S_FETCH;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                end
            end
            default: ;  // S_HALT: idle until reset
        endcase

        // Reset cycle: no pulses and an idle bus, whatever the state was.
        if (rst_i) begin
            pc_inc_o  = 1'b0;
            jmp_en_o  = 1'b0;
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
            acc_ld_o  = 1'b0;
        end
    end

    assign jmp_addr_o  = ir[ADDR_W-1:0];
    assign mem_wdata_o = acc_i;
    assign ir_o        = ir;
    assign halted_o    = (state == S_HALT);

endmodule
